weightmemory_banked: RTL and testbench



---
 rtl/weightmemory_banked.sv | 104 ++++++++++
 tb/tb_weightmemory_banked.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weightmemory_banked.sv
// weightmemory_banked: NUM_BANKS independent ternary weight banks with write-priority
// arbitration and a 2-entry decoded output FIFO behind a valid/ready read port.
module weightmemory_banked #(
    parameter int N_I            = 512,
    parameter int K              = 3,
    parameter int WEIGHT_STAGGER = 8,
    parameter int BANKDEPTH      = 90,
    parameter int NUM_BANKS      = 2,
    parameter int CNT_W          = 16,
    localparam int EFFTRITS  = N_I / WEIGHT_STAGGER,
    localparam int PHYSTRITS = (EFFTRITS + 4) / 5 * 5,
    localparam int PHYSBITS  = PHYSTRITS / 5 * 8,
    localparam int NUMDEC    = PHYSBITS / 8,
    localparam int BW        = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1,
    localparam int AW        = $clog2(BANKDEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wvalid_i,
    input  logic [BW-1:0]            wbank_i,
    input  logic [AW-1:0]            waddr_i,
    input  logic [PHYSBITS-1:0]      wdata_i,
    input  logic                     rvalid_i,
    output logic                     rready_o,
    input  logic [BW-1:0]            rbank_i,
    input  logic [AW-1:0]            raddr_i,
    output logic                     weights_valid_o,
    input  logic                     weights_ready_i,
    output logic [EFFTRITS-1:0][1:0] weights_o,
    output logic [PHYSBITS-1:0]      weights_encoded_o,
    output logic [CNT_W-1:0]         collision_cnt_o,
    output logic                     busy_o
);
    if (K < 1 || NUM_BANKS < 1) begin : g_param_err
        $error("weightmemory_banked: K and NUM_BANKS must be >= 1");
    end

    logic [PHYSBITS-1:0]          mem_q [NUM_BANKS][BANKDEPTH];
    logic [PHYSBITS-1:0]          rdata_q;
    logic [EFFTRITS-1:0][1:0]     dec;
    logic [2*EFFTRITS+PHYSBITS-1:0] buf_q [2];
    logic [1:0]                   cnt_q, cnt_d;
    logic [CNT_W-1:0]             coll_q, coll_d;
    logic                         rptr_q, wptr_q, inflight_q;
    logic                         w_ok, r_ok, coll, push, pop;

    // Byte value is five base-3 digits, LSD first; digit 0/1/2 -> trit 0/+1/-1.
    function automatic logic [1:0] trit(input logic [7:0] b, input int j);
        logic [7:0] q, r;
        q = b;
        for (int i = 0; i < 4; i++) if (i < j) q = q / 8'd3;
        r = q % 8'd3;
        return r == 8'd0 ? 2'b00 : r == 8'd1 ? 2'b01 : 2'b11;
    endfunction

    assign w_ok = wvalid_i && 32'(wbank_i) < NUM_BANKS && 32'(waddr_i) < BANKDEPTH;
    assign r_ok = 32'(rbank_i) < NUM_BANKS && 32'(raddr_i) < BANKDEPTH;
    assign coll = rvalid_i && wvalid_i && wbank_i == rbank_i;
    assign push = inflight_q;
    assign pop  = weights_valid_o && weights_ready_i;
    // A slot freed by this cycle's pop counts as credit, sustaining 1 read/cycle.
    assign rready_o = rvalid_i && !coll && ({1'b0, inflight_q} + cnt_q - {1'b0, pop}) < 2'd2;
    assign cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    assign coll_d = coll && coll_q != '1 ? coll_q + 1'b1 : coll_q;

    always_comb begin
        dec = '0;
        for (int n = 0; n < NUMDEC; n++)
            for (int j = 0; j < 5; j++)
                if (5 * n + j < EFFTRITS) dec[5*n+j] = trit(rdata_q[8*n +: 8], j);
    end

    always_ff @(posedge clk_i) begin
        if (w_ok) mem_q[wbank_i][waddr_i] <= wdata_i;
        if (rready_o) rdata_q <= r_ok ? mem_q[rbank_i][raddr_i] : '0;
        if (push) buf_q[wptr_q] <= {dec, rdata_q};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            rptr_q     <= 1'b0;
            wptr_q     <= 1'b0;
            coll_q     <= '0;
        end else begin
            inflight_q <= rready_o;
            cnt_q      <= cnt_d;
            rptr_q     <= rptr_q ^ pop;
            wptr_q     <= wptr_q ^ push;
            coll_q     <= coll_d;
        end
    end

    assign weights_valid_o = cnt_q != 2'd0;
    assign {weights_o, weights_encoded_o} = weights_valid_o ? buf_q[rptr_q] : '0;
    assign busy_o          = inflight_q || weights_valid_o;
    assign collision_cnt_o = coll_q;

    a_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ({1'b0, inflight_q} + cnt_q) <= 2'd2);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && cnt_q == 2'd2));
endmodule

// File: tb/tb_weightmemory_banked.sv
// tb_weightmemory_banked: scoreboard bench for the banked weight memory.
module tb_weightmemory_banked;
    localparam int ET = 64, PB = 104, AW = 7, DW = 2 * ET;

    logic clk_i = 1'b0, rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          wvalid_i = 1'b0, rvalid_i = 1'b0, weights_ready_i = 1'b1;
    logic          wbank_i = 1'b0, rbank_i = 1'b0;
    logic [AW-1:0] waddr_i = '0, raddr_i = '0;
    logic [PB-1:0] wdata_i = '0;
    logic          rready_o, weights_valid_o, busy_o;
    logic [ET-1:0][1:0] weights_o;
    logic [PB-1:0] weights_encoded_o;
    logic [15:0]   collision_cnt_o;
    logic          s_rready, s_valid, s_busy;
    logic [ET-1:0][1:0] s_w;
    logic [PB-1:0] s_enc;
    logic [1:0]    s_cnt;

    weightmemory_banked dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wvalid_i(wvalid_i), .wbank_i(wbank_i),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .rbank_i(rbank_i), .raddr_i(raddr_i), .weights_valid_o(weights_valid_o),
        .weights_ready_i(weights_ready_i), .weights_o(weights_o),
        .weights_encoded_o(weights_encoded_o), .collision_cnt_o(collision_cnt_o),
        .busy_o(busy_o)
    );

    weightmemory_banked #(.CNT_W(2)) sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .wvalid_i(wvalid_i), .wbank_i(wbank_i),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .rvalid_i(rvalid_i), .rready_o(s_rready),
        .rbank_i(rbank_i), .raddr_i(raddr_i), .weights_valid_o(s_valid),
        .weights_ready_i(weights_ready_i), .weights_o(s_w),
        .weights_encoded_o(s_enc), .collision_cnt_o(s_cnt), .busy_o(s_busy)
    );

    logic [PB-1:0] m_enc [2][128];
    logic [DW-1:0] m_dec [2][128];
    logic [PB-1:0] q_enc [$];
    logic [DW-1:0] q_dec [$];
    int errs = 0, checks = 0, accepts = 0, pops = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Build a word from random base-3 digits so the expected trits are known up front.
    task automatic gen(output logic [PB-1:0] enc, output logic [DW-1:0] dec);
        int v, p, d;
        enc = '0;
        dec = '0;
        for (int n = 0; n < 13; n++) begin
            v = 0;
            p = 1;
            for (int j = 0; j < 5; j++) begin
                d = int'($urandom_range(2));
                v += d * p;
                p *= 3;
                if (5 * n + j < ET) dec[2*(5*n+j) +: 2] = d == 0 ? 2'b00 : d == 1 ? 2'b01 : 2'b11;
            end
            enc[8*n +: 8] = 8'(v);
        end
    endtask

    task automatic set_w(input int b, input int r, input logic [PB-1:0] e, input logic [DW-1:0] d);
        wvalid_i = 1'b1;
        wbank_i  = 1'(b);
        waddr_i  = AW'(r);
        wdata_i  = e;
        if (r < 90) begin
            m_enc[b][r] = e;
            m_dec[b][r] = d;
        end
    endtask

    task automatic wr(input int b, input int r, input logic [PB-1:0] e, input logic [DW-1:0] d);
        set_w(b, r, e, d);
        tick();
        wvalid_i = 1'b0;
    endtask

    task automatic rd(input int b, input int r);
        bit ok = 0;
        rvalid_i = 1'b1;
        rbank_i  = 1'(b);
        raddr_i  = AW'(r);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            ok = rready_o;
        end
        if (!ok) check("rd_timeout", 32'(ok), 1);
        tick();
        rvalid_i = 1'b0;
    endtask

    task automatic lat(input int b, input int r);
        rvalid_i = 1'b1;
        rbank_i  = 1'(b);
        raddr_i  = AW'(r);
        @(negedge clk_i);
        check("lat_accept", rready_o, 1);
        tick();
        rvalid_i = 1'b0;
        @(negedge clk_i);
        check("lat_t1_valid", weights_valid_o, 0);
        check("lat_t1_busy", busy_o, 1);
        @(negedge clk_i);
        check("lat_t2_valid", weights_valid_o, 1);
        tick();
    endtask

    task automatic conflicts(input int n, input int b, input int r, input logic [PB-1:0] e,
                             input logic [DW-1:0] d);
        set_w(b, r, e, d);
        rvalid_i = 1'b1;
        rbank_i  = 1'(b);
        raddr_i  = AW'(r);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            check("coll_stall", rready_o, 0);
            tick();
        end
        wvalid_i = 1'b0;
        @(negedge clk_i);
        check("coll_retry", rready_o, 1);
        tick();
        rvalid_i = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 50; i++) begin
            if (q_enc.size() == 0 && !busy_o) break;
            tick();
        end
        check("drain", 32'(i < 50), 1);
    endtask

    always @(negedge clk_i) if (rst_ni) begin
        if (rvalid_i && rready_o) begin
            accepts++;
            if (raddr_i < 90) begin
                q_enc.push_back(m_enc[rbank_i][raddr_i]);
                q_dec.push_back(m_dec[rbank_i][raddr_i]);
            end else begin
                q_enc.push_back('0);
                q_dec.push_back('0);
            end
        end
        if (weights_valid_o && weights_ready_i) begin
            pops++;
            check("sb_nonempty", 32'(q_enc.size() != 0), 1);
            if (q_enc.size() != 0) begin
                check("enc", weights_encoded_o, q_enc.pop_front());
                check("dec", weights_o, q_dec.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [PB-1:0] e [24];
        logic [DW-1:0] d [24];
        logic [PB-1:0] hold;
        int a0, p0;
        for (int i = 0; i < 24; i++) gen(e[i], d[i]);
        repeat (3) tick();
        check("rst_valid", weights_valid_o, 0);
        check("rst_w", weights_o, 0);
        check("rst_enc", weights_encoded_o, 0);
        check("rst_cnt", collision_cnt_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_rready", rready_o, 0);
        rst_ni = 1'b1;
        tick();

        wr(0, 3, e[0], d[0]);
        wr(1, 3, e[1], d[1]);
        lat(0, 3);
        lat(1, 3);
        drain();
        rd(0, 100);
        drain();

        set_w(1, 5, e[3], d[3]);
        rvalid_i = 1'b1;
        rbank_i  = 1'b0;
        raddr_i  = AW'(3);
        @(negedge clk_i);
        check("diffbank_accept", rready_o, 1);
        tick();
        wvalid_i = 1'b0;
        rvalid_i = 1'b0;
        check("diffbank_cnt", collision_cnt_o, 0);
        drain();
        rd(1, 5);
        drain();

        conflicts(1, 0, 3, e[2], d[2]);
        check("coll_cnt1", collision_cnt_o, 1);
        check("sat_cnt1", s_cnt, 1);
        drain();
        conflicts(3, 1, 7, e[4], d[4]);
        check("coll_cnt4", collision_cnt_o, 4);
        drain();
        conflicts(1, 0, 3, e[2], d[2]);
        check("coll_cnt5", collision_cnt_o, 5);
        check("sat_cnt_sat", s_cnt, 3);
        drain();

        for (int i = 0; i < 16; i++) wr(i % 2, 10 + i, e[8+i], d[8+i]);

        weights_ready_i = 1'b0;
        a0 = accepts;
        hold = '0;
        for (int k = 0; k < 6; k++) begin
            rvalid_i = 1'b1;
            rbank_i  = 1'((accepts - a0) % 2);
            raddr_i  = AW'(10 + accepts - a0);
            if (k == 3) hold = weights_encoded_o;
            tick();
        end
        check("bp_accepts", accepts - a0, 2);
        check("bp_rready", rready_o, 0);
        check("bp_head", weights_encoded_o, e[8]);
        check("bp_head_stable", weights_encoded_o, hold);
        rvalid_i = 1'b0;
        weights_ready_i = 1'b1;
        drain();

        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            rvalid_i = 1'b1;
            rbank_i  = 1'(i % 2);
            raddr_i  = AW'(10 + i);
            @(negedge clk_i);
            check("b2b_accept", rready_o, 1);
            tick();
        end
        rvalid_i = 1'b0;
        tick();
        tick();
        check("b2b_count", pops - p0, 16);
        drain();

        weights_ready_i = 1'b0;
        rvalid_i = 1'b1;
        rbank_i  = 1'b0;
        raddr_i  = AW'(3);
        tick();
        tick();
        rvalid_i = 1'b0;
        check("mid_valid", weights_valid_o, 1);
        check("mid_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", weights_valid_o, 0);
        check("mid_rst_enc", weights_encoded_o, 0);
        check("mid_rst_w", weights_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_cnt", collision_cnt_o, 0);
        q_enc.delete();
        q_dec.delete();
        tick();
        tick();
        rst_ni = 1'b1;
        weights_ready_i = 1'b1;
        tick();
        rd(0, 3);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
